// File: rtl/demux_stream_pkg.sv
// Shared defaults and helpers for the 1-to-N stream demultiplexer.
package demux_stream_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N     = 4;
  localparam int DEF_CNTW  = 8;

  // Upper bounds for the helper functions below. N must not exceed MAX_N
  // and CNTW must not exceed MAX_CNTW.
  localparam int MAX_SELW = 6;
  localparam int MAX_N    = 1 << MAX_SELW;
  localparam int MAX_CNTW = 32;

  // One-hot code for a channel index. Callers truncate the result to N bits.
  function automatic logic [MAX_N-1:0] onehot_sel(input logic [MAX_SELW-1:0] sel);
    logic [MAX_N-1:0] one;
    one = {{(MAX_N-1){1'b0}}, 1'b1};
    return one << sel;
  endfunction

  // Increment that sticks at cnt_max instead of wrapping.
  function automatic logic [MAX_CNTW-1:0] sat_inc(input logic [MAX_CNTW-1:0] cnt,
                                                  input logic [MAX_CNTW-1:0] cnt_max);
    if (cnt >= cnt_max) begin
      return cnt_max;
    end
    return cnt + 1'b1;
  endfunction

endpackage

// File: rtl/demux_onehot_dec.sv
// Target-mask decoder: selected channel (unicast) or every enabled channel
// (broadcast), always qualified by the channel enable mask.
module demux_onehot_dec
  import demux_stream_pkg::*;
#(
  parameter  int N    = DEF_N,
  localparam int SELW = $clog2(N)
) (
  input  logic [SELW-1:0] in_sel,
  input  logic            in_bcast,
  input  logic [N-1:0]    chan_en,
  output logic [N-1:0]    mask
);

  logic [N-1:0] sel_oh;

  assign sel_oh = N'(onehot_sel(MAX_SELW'(in_sel)));

  // Per-channel target bit: enabled and either broadcast or selected.
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign mask[gi] = chan_en[gi] & (in_bcast | sel_oh[gi]);
  end

endmodule

// File: rtl/demux_stream_n.sv
// 1-to-N valid/ready stream demultiplexer with a one-entry hold register.
// A beat is held until every channel in its target mask has taken it;
// beats whose target mask is empty are counted as drops.
module demux_stream_n
  import demux_stream_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int N     = DEF_N,
  parameter  int CNTW  = DEF_CNTW,
  localparam int SELW  = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SELW-1:0]  in_sel,
  input  logic             in_bcast,
  input  logic [N-1:0]     chan_en,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic [CNTW-1:0]  drop_cnt
);

  localparam logic [MAX_CNTW-1:0] CNT_MAX = MAX_CNTW'({CNTW{1'b1}});

  logic [WIDTH-1:0] hold_data_reg, hold_data_next;
  logic [N-1:0]     pend_reg, pend_next;
  logic [CNTW-1:0]  drop_cnt_reg, drop_cnt_next;

  logic [N-1:0] new_mask;
  logic [N-1:0] pend_left;
  logic         accept;

  demux_onehot_dec #(.N(N)) u_dec (
    .in_sel   (in_sel),
    .in_bcast (in_bcast),
    .chan_en  (chan_en),
    .mask     (new_mask)
  );

  // Channels still owed the held beat after this cycle's transfers.
  assign pend_left = pend_reg & ~out_ready;
  // Room for a new beat once nothing would remain pending after this cycle.
  assign in_ready  = !rst && (pend_left == '0);
  assign accept    = in_valid && in_ready;

  // Next-state: retire completed channels, or load a freshly accepted beat.
  always_comb begin
    pend_next      = pend_left;
    hold_data_next = hold_data_reg;
    drop_cnt_next  = drop_cnt_reg;
    if (accept) begin
      pend_next      = new_mask;
      hold_data_next = in_data;
      if (new_mask == '0) begin
        drop_cnt_next = CNTW'(sat_inc(MAX_CNTW'(drop_cnt_reg), CNT_MAX));
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg      <= '0;
      hold_data_reg <= '0;
      drop_cnt_reg  <= '0;
    end else begin
      pend_reg      <= pend_next;
      hold_data_reg <= hold_data_next;
      drop_cnt_reg  <= drop_cnt_next;
    end
  end

  assign out_valid = pend_reg;
  assign drop_cnt  = drop_cnt_reg;

  // Every channel presents the same held word; valid says who should take it.
  for (genvar gi = 0; gi < N; gi++) begin : g_out
    assign out_data[gi*WIDTH +: WIDTH] = hold_data_reg;
  end

endmodule

// File: tb/tb_demux_stream_n.sv
// Bench for demux_stream_n: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_demux_stream_n;

  logic clk;
  logic rst;

  // Instance A: default N=4, WIDTH=8, CNTW=8
  logic        in_valid, in_ready, in_bcast;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  chan_en, out_valid, out_ready;
  logic [31:0] out_data;
  logic [7:0]  drop_cnt;

  // Instance B: N=8, WIDTH=16
  logic         b_in_valid, b_in_ready, b_in_bcast;
  logic [15:0]  b_in_data;
  logic [2:0]   b_in_sel;
  logic [7:0]   b_chan_en, b_out_valid, b_out_ready;
  logic [127:0] b_out_data;
  logic [7:0]   b_drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  demux_stream_n dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast), .chan_en(chan_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_cnt(drop_cnt)
  );

  demux_stream_n #(.WIDTH(16), .N(8), .CNTW(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_sel(b_in_sel), .in_bcast(b_in_bcast),
    .chan_en(b_chan_en), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .drop_cnt(b_drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of instance A ----------------
  // m_owed: channels that have not yet received the held word.
  logic [3:0] m_owed;
  logic [7:0] m_word;
  int         m_drops;
  bit         model_ok = 0;

  always @(posedge clk) begin
    logic [3:0] still_owed;
    logic [3:0] targets;
    if (rst) begin
      m_owed   <= 4'b0;
      m_word   <= 8'h0;
      m_drops  <= 0;
      model_ok <= 1'b1;
    end else begin
      still_owed = 4'b0;
      for (int c = 0; c < 4; c++)
        if (m_owed[c] && !out_ready[c]) still_owed[c] = 1'b1;
      if (in_valid && still_owed == 4'b0) begin
        targets = 4'b0;
        for (int c = 0; c < 4; c++)
          if (chan_en[c] && (in_bcast || int'(in_sel) == c)) targets[c] = 1'b1;
        m_owed <= targets;
        m_word <= in_data;
        if (targets == 4'b0 && m_drops < 255) m_drops <= m_drops + 1;
      end else begin
        m_owed <= still_owed;
      end
    end
  end

  // Per-cycle comparison of instance A against the model.
  always @(negedge clk) begin
    logic exp_ready;
    if (model_ok) begin
      exp_ready = !rst;
      for (int c = 0; c < 4; c++)
        if (m_owed[c] && !out_ready[c]) exp_ready = 1'b0;
      chk("model_in_ready", 128'(in_ready), 128'(exp_ready));
      chk("model_out_valid", 128'(out_valid), 128'(m_owed));
      chk("model_out_data", 128'(out_data), 128'({4{m_word}}));
      chk("model_drop_cnt", 128'(drop_cnt), 128'(m_drops));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [7:0] d, input logic [1:0] s,
                         input logic b);
    in_valid = v;
    in_data  = d;
    in_sel   = s;
    in_bcast = b;
  endtask

  initial begin
    logic [7:0]  s1_data [4];
    logic [15:0] bword;
    s1_data = '{8'h11, 8'h22, 8'h33, 8'h44};

    rst = 1'b1;
    drive_a(1'b0, 8'h0, 2'd0, 1'b0);
    chan_en = 4'b0; out_ready = 4'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_sel = '0; b_in_bcast = 1'b0;
    b_chan_en = '0; b_out_ready = '0;
    tick();
    chk("reset_in_ready", 128'(in_ready), 128'(0));
    tick();
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_drop_cnt", 128'(drop_cnt), 128'(0));

    // 1. Unicast, all ready
    chan_en = 4'b1111; out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, s1_data[i], 2'(i), 1'b0);
      #1;
      chk("s1_in_ready", 128'(in_ready), 128'(1));
      tick();
      chk("s1_out_valid", 128'(out_valid), 128'(4'b0001 << i));
      chk("s1_chan_data", 128'(out_data[i*8 +: 8]), 128'(s1_data[i]));
    end
    drive_a(1'b0, 8'h0, 2'd0, 1'b0);
    tick();

    // 2. Broadcast with staggered readiness
    chan_en = 4'b1011; out_ready = 4'b0000;
    drive_a(1'b1, 8'hA5, 2'd2, 1'b1);
    tick();
    chk("s2_pend_c0", 128'(out_valid), 128'(4'b1011));
    drive_a(1'b1, 8'h5A, 2'd0, 1'b0);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      out_ready = (cyc == 1) ? 4'b0001 : (cyc == 3) ? 4'b0010 : 4'b0000;
      #1;
      chk("s2_in_ready_low", 128'(in_ready), 128'(0));
      tick();
      chk("s2_pend", 128'(out_valid),
          128'((cyc < 3) ? 4'b1010 : 4'b1000));
    end
    out_ready = 4'b1000;
    #1;
    chk("s2_in_ready_c5", 128'(in_ready), 128'(1));
    tick();
    chk("s2_next_valid", 128'(out_valid), 128'(4'b0001));
    chk("s2_next_data", 128'(out_data[7:0]), 128'(8'h5A));
    drive_a(1'b0, 8'h0, 2'd0, 1'b0);
    out_ready = 4'b1111;
    tick();

    // 3. Drop path
    chan_en = 4'b0000;
    for (int i = 0; i < 300; i++) begin
      drive_a(1'b1, 8'($urandom), 2'($urandom), 1'($urandom));
      #1;
      chk("s3_in_ready", 128'(in_ready), 128'(1));
      tick();
      chk("s3_out_valid", 128'(out_valid), 128'(0));
    end
    chk("s3_drop_sat", 128'(drop_cnt), 128'(255));
    drive_a(1'b0, 8'h0, 2'd0, 1'b0);
    tick();

    // 4. Back-pressure with enable snapshot
    chan_en = 4'b1111; out_ready = 4'b1011;
    drive_a(1'b1, 8'h3C, 2'd2, 1'b0);
    tick();
    drive_a(1'b1, 8'h77, 2'd1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) chan_en = 4'b1011;
      #1;
      chk("s4_valid_held", 128'(out_valid), 128'(4'b0100));
      chk("s4_data_held", 128'(out_data[23:16]), 128'(8'h3C));
      chk("s4_in_ready_low", 128'(in_ready), 128'(0));
      tick();
    end
    out_ready = 4'b1111;
    #1;
    chk("s4_in_ready_release", 128'(in_ready), 128'(1));
    tick();
    chk("s4_next_valid", 128'(out_valid), 128'(4'b0010));
    chk("s4_next_data", 128'(out_data[15:8]), 128'(8'h77));
    drive_a(1'b0, 8'h0, 2'd0, 1'b0);
    tick();

    // 5. Reset mid-HOLD
    chan_en = 4'b1111; out_ready = 4'b0000;
    drive_a(1'b1, 8'h99, 2'd2, 1'b0);
    tick();
    drive_a(1'b0, 8'h0, 2'd0, 1'b0);
    chk("s5_hold", 128'(out_valid), 128'(4'b0100));
    rst = 1'b1;
    #1;
    chk("s5_in_ready_rst", 128'(in_ready), 128'(0));
    tick();
    rst = 1'b0;
    chk("s5_valid_cleared", 128'(out_valid), 128'(0));
    chk("s5_drop_cleared", 128'(drop_cnt), 128'(0));
    out_ready = 4'b1111;
    drive_a(1'b1, 8'h42, 2'd3, 1'b0);
    tick();
    chk("s5_after_valid", 128'(out_valid), 128'(4'b1000));
    chk("s5_after_data", 128'(out_data[31:24]), 128'(8'h42));
    drive_a(1'b0, 8'h0, 2'd0, 1'b0);
    tick();

    // Randomized traffic (model compare runs every cycle)
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(99) == 0);
      in_valid  = ($urandom_range(3) != 0);
      in_data   = 8'($urandom);
      in_sel    = 2'($urandom);
      in_bcast  = ($urandom_range(3) == 0);
      chan_en   = ($urandom_range(7) == 0) ? 4'b0 : 4'($urandom);
      out_ready = 4'($urandom) | 4'($urandom);
      tick();
    end
    rst = 1'b0;
    drive_a(1'b0, 8'h0, 2'd0, 1'b0);
    out_ready = 4'b1111;
    tick();

    // 6. Wider instance: N=8, WIDTH=16
    b_chan_en = 8'hFF; b_out_ready = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      bword = (i == 7) ? 16'hBEEF : 16'(16'h1000 + i);
      b_in_valid = 1'b1; b_in_data = bword; b_in_sel = 3'(i); b_in_bcast = 1'b0;
      #1;
      chk("s6_in_ready", 128'(b_in_ready), 128'(1));
      tick();
      chk("s6_out_valid", 128'(b_out_valid), 128'(8'h01 << i));
      chk("s6_chan_data", 128'(b_out_data[i*16 +: 16]), 128'(bword));
    end
    chk("s6_top_slice", 128'(b_out_data[127:112]), 128'(16'hBEEF));
    chk("s6_valid_80", 128'(b_out_valid), 128'(8'h80));
    b_in_valid = 1'b0;
    tick();
    chk("s6_drained", 128'(b_out_valid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_stream_n.md
Name: demux_stream_n

Overview:
- Parametrised 1-to-N stream demultiplexer; successor to the team's fixed 1-to-4, 1-bit combinational demux.
- Accepts one WIDTH-bit beat per cycle on a valid/ready input.
- Routes each beat to one selected output channel (unicast) or to all enabled channels (broadcast).
- Holds the beat in a one-entry register until every targeted channel has accepted it.
- Sits between a single producer and N independent consumers in the lab datapath.

Parameters:
- WIDTH, 8, data bits per beat.
- N, 4, number of output channels; power of two, N >= 2.
- SELW, $clog2(N), select width; derived, never overridden.
- CNTW, 8, width of the saturating drop counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a beat.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  WIDTH  beat payload.
- in_sel  in  SELW  target channel for unicast; ignored when in_bcast=1.
- in_bcast  in  1  1 = broadcast to all enabled channels.
- chan_en  in  N  per-channel enable mask; sampled only at acceptance.
- out_valid  out  N  per-channel valid.
- out_ready  in  N  per-channel ready.
- out_data  out  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]; all channels carry the same held word.
- drop_cnt  out  CNTW  beats accepted with an empty target mask, saturating.

Behaviour:
- State: hold_data[WIDTH], pend[N] (pending one-hot/multi-hot mask), drop_cnt.
- Two implied states: EMPTY (pend==0) and HOLD (pend!=0). No separate state register.
- Reset (rst=1 at clock edge) clears pend, hold_data and drop_cnt to 0. While rst=1, in_ready=0.
- out_valid = pend and out_data = {N{hold_data}}, both taken directly from registers with no combinational path from inputs.
- A channel transfer occurs when pend[i] && out_ready[i]. pend_next = pend & ~out_ready.
- in_ready = !rst && ((pend & ~out_ready) == 0). The block accepts when empty, or when all remaining pending channels complete this cycle. This gives full throughput of 1 beat/cycle when targets are ready.
- Acceptance (in_valid && in_ready):
  - mask = in_bcast ? chan_en : (onehot(in_sel) & chan_en).
  - hold_data <= in_data; pend <= mask.
  - If mask==0, the beat is dropped: pend stays 0 and drop_cnt increments, saturating at 2^CNTW-1 with no wrap.
- Latency: a beat accepted at edge k is visible on out_valid at the cycle following edge k (1 cycle).
- Broadcast completes independently per channel. A channel that accepts early drops its valid; the next beat is accepted only once all targeted channels have accepted.
- chan_en changes while in HOLD do not alter pend; the mask is a snapshot taken at acceptance.
- Simultaneous final channel acceptance and new input acceptance in the same cycle: pend is loaded with the new mask, and the old beat counts as delivered.
- in_sel, in_bcast and in_data are don't-care when in_valid=0.
- Reset mid-HOLD: the pending beat is discarded with no output transfer. out_valid is 0 in the cycle after the reset edge.
- out_ready on non-pending channels has no effect.

Decomposition:
- Package demux_stream_pkg holds:
  - default WIDTH/N/CNTW localparams;
  - a function onehot_sel(sel) returning an N-bit one-hot;
  - a saturating-increment function for drop_cnt.
- Sub-module demux_onehot_dec (combinational): inputs in_sel, in_bcast, chan_en; output mask[N]. This is the parametrised replacement for the fixed 4-way select decoder.
- The top module contains the hold register, pend mask, ready logic and counter.

Test Plan:
1. Unicast, all ready:
   - Stimulus: N=4, chan_en=4'b1111, out_ready=4'b1111; beats 0x11,0x22,0x33,0x44 with sel=0,1,2,3 on consecutive cycles.
   - Required: out_valid one-hot 0001,0010,0100,1000 each 1 cycle later; in_ready constantly 1; correct data on each channel.
2. Broadcast with staggered readiness:
   - Stimulus: chan_en=4'b1011, in_bcast=1, data 0xA5; out_ready[0] high at cycle 1, [1] at cycle 3, [3] at cycle 5.
   - Required: pend goes 1011 -> 1010 -> 1000 -> 0000; in_ready=0 until cycle 5; next beat accepted at cycle 5.
3. Drop path:
   - Stimulus: chan_en=4'b0000, 300 valid beats.
   - Required: all accepted (in_ready=1); out_valid stays 0; drop_cnt reaches 255 and holds.
4. Back-pressure with snapshot:
   - Stimulus: sel=2, out_ready[2]=0 for 10 cycles; toggle chan_en[2] to 0 mid-hold.
   - Required: out_valid[2] stays 1 with data stable; the beat is delivered when out_ready[2]=1; in_ready stays 0 until then.
5. Reset mid-operation:
   - Stimulus: HOLD with pend=0100, assert rst for 1 cycle.
   - Required: in_ready=0 during reset; pend=0, drop_cnt=0, out_valid=0 the following cycle; the next beat is routed normally.
6. Generic check:
   - Stimulus: rerun scenario 1 with N=8, WIDTH=16, sel=7, data 0xBEEF.
   - Required: out_data bits [127:112]=0xBEEF, out_valid=8'h80.
